// File: rtl/halflife_pkg.sv
// Shared types for the half-life decay timer.
//   hl_state_e : controller state (IDLE = manual counting, DECAY = autonomous
//                halving, DONE = count reached zero by decay).
package halflife_pkg;

    localparam int unsigned HL_STATE_W = 2;

    typedef enum logic [HL_STATE_W-1:0] {
        IDLE  = 2'd0,
        DECAY = 2'd1,
        DONE  = 2'd2
    } hl_state_e;

endpackage

// File: rtl/halflife_prescaler.sv
// Half-life prescaler: counts cycles while enabled and flags the cycle on
// which one half-life period has elapsed.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the count to 0 (takes precedence over enable)
//   enable   : advance the count this cycle
//   period   : cycles per half-life; 0 behaves as 1
//   tick     : high while enabled and the count has reached max(period,1)-1
module halflife_prescaler #(
    parameter int unsigned PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic [PW-1:0] period,
    output logic          tick
);

    logic [PW-1:0] count;
    logic [PW-1:0] limit;

    // Terminal count; period 0 folds onto period 1.
    always_comb begin
        limit = (period == '0) ? '0 : period - PW'(1);
    end

    // >= rather than == so that shrinking the period mid-run fires at once
    // instead of wrapping all the way around.
    assign tick = enable && (count >= limit);

    // The count restarts at the terminal cycle, so it can never overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + PW'(1);
        end
    end

endmodule

// File: rtl/halflife_decay_timer.sv
// Half-life decay timer: WIDTH-bit loadable up/down counter that, on request,
// halves its count every `period` cycles until it reaches zero.
// Build option: define HALFLIFE_SAT_EN to make manual up/down saturate at
// 2^WIDTH-1 / 0 instead of wrapping. Decay behaviour is the same either way.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load, in   : load `in` into the count (returns to manual mode)
//   up, down   : manual increment / decrement (only one at a time counts)
//   decay      : level request for decay mode
//   period     : cycles per half-life (0 behaves as 1)
//   out        : registered count
//   half_pulse : one-cycle pulse coincident with each halved value on `out`
//   decaying   : high while in DECAY
//   done       : high while in DONE
module halflife_decay_timer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             up,
    input  logic             down,
    input  logic             decay,
    input  logic [PW-1:0]    period,
    output logic [WIDTH-1:0] out,
    output logic             half_pulse,
    output logic             decaying,
    output logic             done
);

    import halflife_pkg::*;

    hl_state_e        state, state_nx;
    logic [WIDTH-1:0] out_nx;
    logic             half_nx;
    logic             pre_en;
    logic             pre_clear;
    logic             tick;

    // Prescaler runs only while decay is actually proceeding; any other
    // situation (load, abort, IDLE, DONE) leaves it cleared for the next run.
    assign pre_en    = !load && (state == DECAY) && decay;
    assign pre_clear = !pre_en;

    halflife_prescaler #(
        .PW (PW)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (pre_clear),
        .enable (pre_en),
        .period (period),
        .tick   (tick)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out        <= '0;
            half_pulse <= 1'b0;
            decaying   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            out        <= out_nx;
            half_pulse <= half_nx;
            decaying   <= (state_nx == DECAY);
            done       <= (state_nx == DONE);
        end
    end

    // Next-state and next-count logic; load overrides every state action.
    always_comb begin
        state_nx = state;
        out_nx   = out;
        half_nx  = 1'b0;

        if (load) begin
            out_nx   = in;
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (up && !down) begin
`ifdef HALFLIFE_SAT_EN
                        if (out != '1) out_nx = out + WIDTH'(1);
`else
                        out_nx = out + WIDTH'(1);
`endif
                    end else if (down && !up) begin
`ifdef HALFLIFE_SAT_EN
                        if (out != '0) out_nx = out - WIDTH'(1);
`else
                        out_nx = out - WIDTH'(1);
`endif
                    end
                    // Entry is judged on the pre-update count.
                    if (decay && (out != '0)) state_nx = DECAY;
                end
                DECAY: begin
                    if (!decay) begin
                        state_nx = IDLE;
                    end else if (tick) begin
                        out_nx  = out >> 1;
                        half_nx = 1'b1;
                        // Halving yields zero exactly when only bit 0 was set.
                        if (out[WIDTH-1:1] == '0) state_nx = DONE;
                    end
                end
                DONE: begin
                    out_nx = '0;
                    if (!decay) state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_halflife_decay_timer.sv
// Self-checking bench for halflife_decay_timer (WIDTH=8, PW=16).
module tb_halflife_decay_timer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned PW    = 16;

`ifdef HALFLIFE_SAT_EN
    localparam int EXP_UP_255 = 255;
    localparam int EXP_DN_0   = 0;
`else
    localparam int EXP_UP_255 = 0;
    localparam int EXP_DN_0   = 255;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             up;
    logic             down;
    logic             decay;
    logic [PW-1:0]    period;
    logic [WIDTH-1:0] out;
    logic             half_pulse;
    logic             decaying;
    logic             done;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = manual, 1 = decaying, 2 = done.
    int m_out     = 0;
    int m_mode    = 0;
    int m_elapsed = 0;
    bit m_half    = 1'b0;

    always #5 clk = ~clk;

    halflife_decay_timer #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .in         (din),
        .up         (up),
        .down       (down),
        .decay      (decay),
        .period     (period),
        .out        (out),
        .half_pulse (half_pulse),
        .decaying   (decaying),
        .done       (done)
    );

    typedef struct {
        string name;
        bit    r;
        bit    l;
        int    din;
        bit    u;
        bit    d;
        bit    dc;
        int    p;
        int    eout;
        bit    ehalf;
        bit    edec;
        bit    edone;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(string nm, bit r, bit l, int dv, bit u, bit d,
                                bit dc, int p, int eo, bit eh, bit ed, bit edn);
        vec_t v;
        v.name = nm; v.r = r; v.l = l; v.din = dv; v.u = u; v.d = d; v.dc = dc;
        v.p = p; v.eout = eo; v.ehalf = eh; v.edec = ed; v.edone = edn;
        return v;
    endfunction

    function automatic int m_inc(int v);
`ifdef HALFLIFE_SAT_EN
        return (v == 255) ? 255 : v + 1;
`else
        return (v + 1) % 256;
`endif
    endfunction

    function automatic int m_dec(int v);
`ifdef HALFLIFE_SAT_EN
        return (v == 0) ? 0 : v - 1;
`else
        return (v + 255) % 256;
`endif
    endfunction

    // Advance the model by one clock using the inputs applied to that edge.
    task automatic model_step();
        int old;
        int p;
        if (rst) begin
            m_out = 0; m_mode = 0; m_elapsed = 0; m_half = 1'b0;
        end else if (load) begin
            m_out = int'(din); m_mode = 0; m_elapsed = 0; m_half = 1'b0;
        end else begin
            m_half = 1'b0;
            case (m_mode)
                0: begin
                    old = m_out;
                    if (up && !down) m_out = m_inc(m_out);
                    else if (down && !up) m_out = m_dec(m_out);
                    if (decay && old != 0) begin
                        m_mode = 1; m_elapsed = 0;
                    end
                end
                1: begin
                    if (!decay) begin
                        m_mode = 0; m_elapsed = 0;
                    end else begin
                        p = (period == 0) ? 1 : int'(period);
                        if (m_elapsed + 1 >= p) begin
                            m_out = m_out / 2; m_elapsed = 0; m_half = 1'b1;
                            if (m_out == 0) m_mode = 2;
                        end else begin
                            m_elapsed++;
                        end
                    end
                end
                default: begin
                    m_out = 0;
                    if (!decay) m_mode = 0;
                end
            endcase
        end
    endtask

    task automatic set_in(bit r, bit l, int dv, bit u, bit d, bit dc, int p);
        rst = r; load = l; din = WIDTH'(dv); up = u; down = d; decay = dc;
        period = PW'(p);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(string nm, int eo, bit eh, bit ed, bit edn);
        total++;
        if (out !== WIDTH'(eo) || half_pulse !== eh || decaying !== ed || done !== edn) begin
            bad++;
            $display("FAIL %s: got out=%0d half=%0b dec=%0b done=%0b, want out=%0d half=%0b dec=%0b done=%0b",
                     nm, out, half_pulse, decaying, done, eo, eh, ed, edn);
        end
    endtask

    task automatic step_check(string nm, int eo, bit eh, bit ed, bit edn);
        cycle();
        check(nm, eo, eh, ed, edn);
    endtask

    initial begin
        int vals[7];
        int pulses;
        int prev;
        int exp_v;
        bit hit;

        // name, rst, load, in, up, down, decay, period -> out, half, dec, done
        vt.push_back(mk("reset",        1,0,  0, 0,0,0,4,   0,0,0,0));
        vt.push_back(mk("load200",      0,1,200, 0,0,0,4, 200,0,0,0));
        vt.push_back(mk("up1",          0,0,  0, 1,0,0,4, 201,0,0,0));
        vt.push_back(mk("up2",          0,0,  0, 1,0,0,4, 202,0,0,0));
        vt.push_back(mk("up3",          0,0,  0, 1,0,0,4, 203,0,0,0));
        vt.push_back(mk("updown_hold",  0,0,  0, 1,1,0,4, 203,0,0,0));
        vt.push_back(mk("none_hold",    0,0,  0, 0,0,0,4, 203,0,0,0));
        vt.push_back(mk("down1",        0,0,  0, 0,1,0,4, 202,0,0,0));
        vt.push_back(mk("load255",      0,1,255, 0,0,0,4, 255,0,0,0));
        vt.push_back(mk("up_at_max",    0,0,  0, 1,0,0,4, EXP_UP_255,0,0,0));
        vt.push_back(mk("load0",        0,1,  0, 0,0,0,4,   0,0,0,0));
        vt.push_back(mk("down_at_0",    0,0,  0, 0,1,0,4, EXP_DN_0,0,0,0));
        vt.push_back(mk("load0b",       0,1,  0, 0,0,0,4,   0,0,0,0));
        vt.push_back(mk("decay_zero1",  0,0,  0, 0,0,1,4,   0,0,0,0));
        vt.push_back(mk("decay_zero2",  0,0,  0, 0,0,1,4,   0,0,0,0));
        vt.push_back(mk("load8_decay",  0,1,  8, 0,0,1,0,   8,0,0,0));
        vt.push_back(mk("p0_enter",     0,0,  0, 0,0,1,0,   8,0,1,0));
        vt.push_back(mk("p0_h1",        0,0,  0, 0,0,1,0,   4,1,1,0));
        vt.push_back(mk("p0_h2",        0,0,  0, 0,0,1,0,   2,1,1,0));
        vt.push_back(mk("p0_h3",        0,0,  0, 0,0,1,0,   1,1,1,0));
        vt.push_back(mk("p0_h4_done",   0,0,  0, 0,0,1,0,   0,1,0,1));
        vt.push_back(mk("done_hold",    0,0,  0, 0,0,1,0,   0,0,0,1));
        vt.push_back(mk("done_exit",    0,0,  0, 0,0,0,0,   0,0,0,0));
        vt.push_back(mk("load8_p1",     0,1,  8, 0,0,0,1,   8,0,0,0));
        vt.push_back(mk("p1_enter",     0,0,  0, 0,0,1,1,   8,0,1,0));
        vt.push_back(mk("p1_h1",        0,0,  0, 0,0,1,1,   4,1,1,0));
        vt.push_back(mk("p1_h2",        0,0,  0, 0,0,1,1,   2,1,1,0));
        vt.push_back(mk("p1_h3",        0,0,  0, 0,0,1,1,   1,1,1,0));
        vt.push_back(mk("p1_h4_done",   0,0,  0, 0,0,1,1,   0,1,0,1));
        vt.push_back(mk("done_up_ign",  0,0,  0, 1,0,1,1,   0,0,0,1));
        vt.push_back(mk("done_exit2",   0,0,  0, 0,0,0,1,   0,0,0,0));
        vt.push_back(mk("load5",        0,1,  5, 0,0,0,4,   5,0,0,0));
        vt.push_back(mk("enter_with_up",0,0,  0, 1,0,1,4,   6,0,1,0));
        vt.push_back(mk("decay_up_ign", 0,0,  0, 1,0,1,4,   6,0,1,0));
        vt.push_back(mk("abort",        0,0,  0, 0,0,0,4,   6,0,0,0));

        set_in(1, 0, 0, 0, 0, 0, 4);
        cycle();
        foreach (vt[i]) begin
            set_in(vt[i].r, vt[i].l, vt[i].din, vt[i].u, vt[i].d, vt[i].dc, vt[i].p);
            step_check(vt[i].name, vt[i].eout, vt[i].ehalf, vt[i].edec, vt[i].edone);
        end

        // Full decay from 100 with period 4.
        vals[0] = 50; vals[1] = 25; vals[2] = 12; vals[3] = 6;
        vals[4] = 3;  vals[5] = 1;  vals[6] = 0;
        set_in(0, 1, 100, 0, 0, 0, 4);
        step_check("load100", 100, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 1, 4);
        step_check("d100_enter", 100, 0, 1, 0);
        pulses = 0;
        prev = 100;
        for (int k = 0; k < 7; k++) begin
            for (int c = 1; c <= 4; c++) begin
                cycle();
                if (half_pulse === 1'b1) pulses++;
                if (c < 4) check("d100_wait", prev, 0, 1, 0);
                else check("d100_halve", vals[k], 1, vals[k] != 0, vals[k] == 0);
            end
            prev = vals[k];
        end
        total++;
        if (pulses != 7) begin
            bad++;
            $display("FAIL d100_pulse_count: got %0d, want 7", pulses);
        end
        set_in(0, 0, 0, 0, 0, 0, 4);
        step_check("d100_exit", 0, 0, 0, 0);

        // Load during decay, then abort mid-period; both clear the prescaler.
        set_in(0, 1, 100, 0, 0, 0, 4);
        step_check("int_load100", 100, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 1, 4);
        step_check("int_enter", 100, 0, 1, 0);
        for (int c = 1; c <= 6; c++) begin
            cycle();
            if (c == 4) check("int_h1", 50, 1, 1, 0);
            else check("int_run", (c < 4) ? 100 : 50, 0, 1, 0);
        end
        set_in(0, 1, 77, 0, 0, 1, 4);
        step_check("int_load77", 77, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 1, 4);
        step_check("int_reenter", 77, 0, 1, 0);
        for (int c = 1; c <= 4; c++)
            step_check("int_after_load", (c == 4) ? 38 : 77, c == 4, 1, 0);
        for (int c = 1; c <= 2; c++)
            step_check("int_partial", 38, 0, 1, 0);
        set_in(0, 0, 0, 0, 0, 0, 4);
        step_check("int_abort", 38, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 1, 4);
        step_check("int_reenter2", 38, 0, 1, 0);
        for (int c = 1; c <= 4; c++)
            step_check("int_after_abort", (c == 4) ? 19 : 38, c == 4, 1, 0);

        // Reset held two cycles in the middle of a decay.
        for (int c = 0; c < 2; c++) begin
            set_in(1, 0, 0, 1, 0, 1, 4);
            step_check("mid_reset", 0, 0, 0, 0);
        end

        // Randomised run against the model, period changing freely.
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(0, 63) == 0),
                   ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, 5)));
            cycle();
            exp_v = m_out;
            hit = (m_mode == 1);
            check("random", exp_v, m_half, hit, m_mode == 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/halflife_decay_timer.md
# halflife_decay_timer

Parametrised successor to the team's 4-bit load/up/down half-life counter. It is a WIDTH-bit loadable up/down counter with an autonomous decay mode: while decaying, the count halves every `period` clock cycles until it reaches zero. It reports each halving event and completion. It sits beside the existing counter and drives display and status logic.

## Interface
- `WIDTH`, 8: count width, must be ≥ 2.
- `PW`, 16: width of the `period` input and the internal prescaler.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `load` input 1: load `in` into the count.
- `in` input WIDTH: load value.
- `up` input 1: increment in manual mode.
- `down` input 1: decrement in manual mode.
- `decay` input 1: level request for decay mode.
- `period` input PW: cycles per half-life; 0 is treated as 1.
- `out` output WIDTH: registered count.
- `half_pulse` output 1: registered, high for 1 cycle on each halving.
- `decaying` output 1: high while state is DECAY.
- `done` output 1: high while state is DONE.

## Operation
- States:
  - IDLE: manual mode.
  - DECAY: autonomous halving.
  - DONE: count reached 0 by decay.
- Priority per cycle: `rst` > `load` > state action.
- `rst`: out=0, state IDLE, prescaler 0, all flags 0.
- `load` (any state): out=`in`, state IDLE, prescaler 0, half_pulse 0. `decay` is ignored that cycle.
- IDLE:
  - `up`&!`down`: out+1.
  - `down`&!`up`: out−1.
  - Both or neither: hold.
  - `decay`=1 and out≠0: go to DECAY, prescaler 0. The up/down action of that cycle still applies.
  - `decay`=1 and out==0: stay IDLE.
- DECAY:
  - `up`/`down` are ignored.
  - The prescaler increments each cycle.
  - When prescaler == max(period,1)−1: out = out>>1 (truncating), prescaler 0, half_pulse=1.
  - If the new out is 0: go to DONE.
  - `decay`=0: abort to IDLE, out held, prescaler 0.
- DONE: out=0 held. `decay`=0 returns to IDLE; `up`/`down` are ignored while in DONE.
- `period` is sampled every cycle. A change mid-decay takes effect at the next compare. If the prescaler is already ≥ the new period−1, it fires at that compare.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Load/up/down: result is visible 1 cycle after the input is sampled.
- Decay asserted at edge t (IDLE, out≠0): `decaying`=1 after edge t.
- With period P, the first halving is visible after edge t+P, then every P cycles after that. `half_pulse` is coincident with the new `out`.
- `done` rises on the same edge where out becomes 0 in DECAY.
- Decay from value V needs floor(log2 V)+1 halvings to reach 0.

## Configuration
- `HALFLIFE_SAT_EN` defined: manual up saturates at 2^WIDTH−1, and manual down saturates at 0.
- `HALFLIFE_SAT_EN` undefined: manual up/down wrap modulo 2^WIDTH (255+1→0, 0−1→255 at WIDTH=8).
- Decay behaviour is identical in both builds.

## Structure
- `halflife_pkg`: state enum `hl_state_e` {IDLE, DECAY, DONE}, 2-bit encoding, IDLE=0.
- Sub-module `halflife_prescaler`:
  - PW-bit counter with clear/enable inputs and a `tick` output that fires when count == max(period,1)−1.
  - Synchronous active-high reset.
- Top level: state register, count register, flag registers.

## Test plan
- Reset: `rst` high 2 cycles mid-operation → out=0, half_pulse=0, decaying=0, done=0 on the next cycle.
- Manual count:
  - load 200, then `up` 3 cycles → 203.
  - `up`&`down` together → 203 held.
  - `down` 1 cycle → 202.
- Boundary:
  - load 255, `up` → 0 without macro, 255 with `HALFLIFE_SAT_EN`.
  - load 0, `down` → 255 without macro, 0 with it.
- Decay:
  - load 100, period=4, decay=1 → out 50,25,12,6,3,1,0 at 4-cycle spacing, with 7 half_pulses.
  - done=1 on the edge where out becomes 0; decay=0 then → IDLE.
- Interrupts:
  - During decay, load 77 → out=77, IDLE, prescaler cleared.
  - decay=0 mid-period → out held, decaying=0.
- Edge periods:
  - period=0 and period=1 → halving every cycle (out 8→4→2→1→0 over 4 cycles).
  - decay with out=0 → stays IDLE, done=0.
